// File: rtl/imem_if.sv
// Fetch-side bus between the processor fetch stage (master) and the
// instruction memory (slave).
interface imem_if;
  // Handshake: a request transfers on any cycle where proc2Imem_req and
  // Imem2proc_gnt are both high. While not granted, the master holds req/addr.
  // A response is valid for exactly one cycle when Imem2proc_valid is high.
  // There is no response back-pressure. Responses come back in request order.
  logic        proc2Imem_req;
  logic [31:0] proc2Imem_addr;
  logic        Imem2proc_gnt;
  logic        Imem2proc_valid;
  logic [31:0] Imem2proc_data;
  logic [31:0] Imem2proc_addr;
  logic        Imem2proc_error;

  modport master (
    output proc2Imem_req, proc2Imem_addr,
    input  Imem2proc_gnt, Imem2proc_valid, Imem2proc_data, Imem2proc_addr,
           Imem2proc_error
  );

  modport slave (
    input  proc2Imem_req, proc2Imem_addr,
    output Imem2proc_gnt, Imem2proc_valid, Imem2proc_data, Imem2proc_addr,
           Imem2proc_error
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency, in-order fetch responses with
// flush, a program-load write port and a saturating accepted-request counter.
module imem_responder #(
  parameter int          MEM_WORDS = 256,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BAD_WORD  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  imem_if.slave       bus,
  input  logic        flush,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic [15:0] req_count
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic [31:0] addr;
    logic        error;
  } resp_t;

  logic [31:0]   mem [MEM_WORDS];
  logic          accept;
  logic          fetch_in_range;
  logic          load_in_range;
  logic [AW-1:0] fetch_idx;
  logic [AW-1:0] load_idx;
  resp_t         fetch_rd;
  resp_t         pipe [LATENCY];
  resp_t         out_q;
  logic          unused_addr_bits;

  // Load owns the array in its cycle, so a fetch is never granted alongside it.
  assign bus.Imem2proc_gnt = ~rst & ~load_en;
  assign accept            = bus.proc2Imem_req & bus.Imem2proc_gnt;

  assign fetch_idx      = bus.proc2Imem_addr[AW+1:2];
  assign fetch_in_range = (bus.proc2Imem_addr[31:AW+2] == '0);
  assign load_idx       = load_addr[AW+1:2];
  assign load_in_range  = (load_addr[31:AW+2] == '0);

  assign unused_addr_bits = ^{bus.proc2Imem_addr[1:0], load_addr[1:0]};

  always_comb begin
    fetch_rd = '0;
    if (accept) begin
      fetch_rd.valid = 1'b1;
      fetch_rd.addr  = {bus.proc2Imem_addr[31:2], 2'b00};
      fetch_rd.error = ~fetch_in_range;
      fetch_rd.data  = fetch_in_range ? mem[fetch_idx] : BAD_WORD;
    end
  end

  // The array is deliberately not reset; program contents survive rst.
  always_ff @(posedge clk) begin
    if (load_en && load_in_range) begin
      mem[load_idx] <= load_data;
    end
  end

  // Stage 0 always takes the new accept so a redirect issued with flush survives;
  // every older stage and the output register are wiped on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe[i] <= '0;
      end
      out_q <= '0;
    end else begin
      pipe[0] <= fetch_rd;
      for (int i = 1; i < LATENCY; i++) begin
        pipe[i] <= flush ? '0 : pipe[i-1];
      end
      out_q <= flush ? '0 : pipe[LATENCY-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_count <= '0;
    end else if (accept && (req_count != 16'hFFFF)) begin
      req_count <= req_count + 16'd1;
    end
  end

  assign bus.Imem2proc_valid = out_q.valid;
  assign bus.Imem2proc_data  = out_q.data;
  assign bus.Imem2proc_addr  = out_q.addr;
  assign bus.Imem2proc_error = out_q.error;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a timestamped response-queue model checked
// every cycle, plus literal expectations per scenario.
module tb_imem_responder;

  localparam int          LATENCY   = 2;
  localparam int          MEM_WORDS = 256;
  localparam logic [31:0] BAD_WORD  = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic [15:0] req_count;

  imem_if bus ();

  imem_responder #(
    .MEM_WORDS(MEM_WORDS),
    .LATENCY  (LATENCY),
    .BAD_WORD (BAD_WORD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flush    (flush),
    .load_en  (load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .req_count(req_count)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted fetch becomes an entry due LATENCY edges after the edge that
  // sampled it; flush drops everything older, reset drops everything.
  typedef struct packed {
    int          due;
    logic [31:0] data;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [MEM_WORDS];
  int          model_cnt = 0;
  int          cyc = 0;

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = 32'h0;
  end

  always @(posedge clk) begin
    exp_t e;
    int   widx;
    cyc++;
    if (!rst) begin
      if (flush) exp_q.delete();
      if (bus.proc2Imem_req && !load_en) begin
        widx   = int'(bus.proc2Imem_addr >> 2);
        e.due  = cyc + LATENCY;
        e.addr = bus.proc2Imem_addr & 32'hFFFF_FFFC;
        e.err  = (bus.proc2Imem_addr >> 2) >= 32'(MEM_WORDS);
        e.data = e.err ? BAD_WORD : model_mem[widx % MEM_WORDS];
        exp_q.push_back(e);
        model_cnt++;
      end
    end
    if (load_en && ((load_addr >> 2) < 32'(MEM_WORDS))) begin
      model_mem[int'(load_addr >> 2)] = load_data;
    end
  end

  always @(posedge rst) begin
    exp_q.delete();
    model_cnt = 0;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] exp_cnt;
    exp_cnt = (model_cnt > 65535) ? 16'hFFFF : 16'(model_cnt);
    if (rst) begin
      chk("rst_valid", 32'(bus.Imem2proc_valid), 32'h0);
      chk("rst_data",  bus.Imem2proc_data, 32'h0);
      chk("rst_addr",  bus.Imem2proc_addr, 32'h0);
      chk("rst_error", 32'(bus.Imem2proc_error), 32'h0);
      chk("rst_gnt",   32'(bus.Imem2proc_gnt), 32'h0);
      chk("rst_count", 32'(req_count), 32'h0);
    end else begin
      e = '0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        chk("resp_valid", 32'(bus.Imem2proc_valid), 32'h1);
      end else begin
        chk("resp_valid", 32'(bus.Imem2proc_valid), 32'h0);
      end
      chk("resp_data",  bus.Imem2proc_data, e.data);
      chk("resp_addr",  bus.Imem2proc_addr, e.addr);
      chk("resp_error", 32'(bus.Imem2proc_error), 32'(e.err));
      chk("gnt",        32'(bus.Imem2proc_gnt), 32'(!load_en));
      chk("req_count",  32'(req_count), 32'(exp_cnt));
    end
  end

  // ---------------- response capture for literal checks ----------------
  typedef struct packed {
    int          cyc;
    logic [31:0] data;
    logic [31:0] addr;
    logic        err;
  } seen_t;

  seen_t seen_q[$];

  always @(negedge clk) begin
    seen_t s;
    if (!rst && bus.Imem2proc_valid) begin
      s.cyc  = cyc;
      s.data = bus.Imem2proc_data;
      s.addr = bus.Imem2proc_addr;
      s.err  = bus.Imem2proc_error;
      seen_q.push_back(s);
    end
  end

  function automatic seen_t seen_at(input int i);
    seen_t s;
    s = '1;
    if (i < seen_q.size()) s = seen_q[i];
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic [31:0] a, input logic f,
                       input logic le, input logic [31:0] la, input logic [31:0] ld);
    @(posedge clk);
    #1;
    bus.proc2Imem_req  = r;
    bus.proc2Imem_addr = a;
    flush              = f;
    load_en            = le;
    load_addr          = la;
    load_data          = ld;
  endtask

  task automatic fetch(input logic [31:0] a);
    drive(1'b1, a, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 32'h0, 1'b0, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // ---------------- directed scenarios ----------------
  int c0;

  initial begin
    bus.proc2Imem_req  = 1'b0;
    bus.proc2Imem_addr = 32'h0;
    flush     = 1'b0;
    load_en   = 1'b0;
    load_addr = 32'h0;
    load_data = 32'h0;
    rst       = 1'b0;
    #1 rst    = 1'b1;

    // Reset and latency: program loaded while in reset.
    load(32'h0, 32'h11);
    load(32'h4, 32'h22);
    load(32'h8, 32'h33);
    load(32'hC, 32'h44);
    idle(1);
    chk("t1_rst_count", 32'(req_count), 32'h0);
    chk("t1_rst_valid", 32'(bus.Imem2proc_valid), 32'h0);
    chk("t1_rst_gnt",   32'(bus.Imem2proc_gnt), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    seen_q.delete();
    fetch(32'h0);
    c0 = cyc;
    fetch(32'h4);
    fetch(32'h8);
    fetch(32'hC);
    idle(5);
    chk("t1_n_resp", 32'(seen_q.size()), 32'd4);
    // Sampled at the edge after c0, visible LATENCY edges later.
    chk("t1_latency", 32'(seen_at(0).cyc - c0), 32'd3);
    chk("t1_d0", seen_at(0).data, 32'h11);
    chk("t1_d1", seen_at(1).data, 32'h22);
    chk("t1_d2", seen_at(2).data, 32'h33);
    chk("t1_d3", seen_at(3).data, 32'h44);
    chk("t1_a3", seen_at(3).addr, 32'hC);
    chk("t1_count", 32'(req_count), 32'd4);

    // Flush: redirect to 8 alongside flush; 0 and 4 must vanish.
    seen_q.delete();
    fetch(32'h0);
    c0 = cyc;
    fetch(32'h4);
    drive(1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 32'h0);
    idle(6);
    chk("t2_n_resp", 32'(seen_q.size()), 32'd1);
    chk("t2_data",   seen_at(0).data, 32'h33);
    chk("t2_addr",   seen_at(0).addr, 32'h8);
    chk("t2_timing", 32'(seen_at(0).cyc - c0), 32'd5);
    chk("t2_count",  32'(req_count), 32'd7);

    // Load priority over a colliding fetch.
    seen_q.delete();
    drive(1'b1, 32'h10, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    #1 chk("t3_gnt_load", 32'(bus.Imem2proc_gnt), 32'h0);
    fetch(32'h10);
    c0 = cyc;
    #1 chk("t3_gnt_fetch", 32'(bus.Imem2proc_gnt), 32'h1);
    idle(5);
    chk("t3_n_resp", 32'(seen_q.size()), 32'd1);
    chk("t3_data",   seen_at(0).data, 32'hDEAD_BEEF);
    chk("t3_timing", 32'(seen_at(0).cyc - c0), 32'd3);
    chk("t3_count",  32'(req_count), 32'd8);

    // Out of range fetch and ignored out-of-range load.
    seen_q.delete();
    fetch(32'h400);
    idle(1);
    load(32'h400, 32'h5555_AAAA);
    fetch(32'h0);
    idle(5);
    chk("t4_n_resp", 32'(seen_q.size()), 32'd2);
    chk("t4_err",    32'(seen_at(0).err), 32'h1);
    chk("t4_data",   seen_at(0).data, BAD_WORD);
    chk("t4_addr",   seen_at(0).addr, 32'h400);
    chk("t4_mem0",   seen_at(1).data, 32'h11);
    chk("t4_count",  32'(req_count), 32'd10);

    // Async reset pulse between edges while responses are in flight.
    seen_q.delete();
    fetch(32'h4);
    fetch(32'h8);
    idle(2);
    #2 rst = 1'b1;
    #1;
    chk("t5_valid", 32'(bus.Imem2proc_valid), 32'h0);
    chk("t5_data",  bus.Imem2proc_data, 32'h0);
    chk("t5_addr",  bus.Imem2proc_addr, 32'h0);
    chk("t5_err",   32'(bus.Imem2proc_error), 32'h0);
    chk("t5_gnt",   32'(bus.Imem2proc_gnt), 32'h0);
    chk("t5_count", 32'(req_count), 32'h0);
    rst = 1'b0;
    idle(4);
    chk("t5_no_late", 32'(seen_q.size()), 32'd0);
    fetch(32'hC);
    idle(5);
    chk("t5_refetch", seen_at(0).data, 32'h44);
    chk("t5_count1",  32'(req_count), 32'd1);

    // Unaligned address, then counter saturation.
    seen_q.delete();
    fetch(32'h7);
    idle(5);
    chk("t6_data", seen_at(0).data, 32'h22);
    chk("t6_addr", seen_at(0).addr, 32'h4);
    repeat (65540) fetch(32'h0);
    idle(5);
    chk("t6_sat", 32'(req_count), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
